// File: rtl/user_button_event_collector.sv
// user_button_event_collector
// Accepts one event per debounced button press and queues the button index
// in a first-word-fall-through FIFO. Buttons compete for the FIFO through a
// round-robin arbiter, and at most one button is accepted per cycle.
// Build option USER_BUTTON_EVENT_DROP_EN: a press that arrives while the FIFO
// is full is still acknowledged but is not stored. Each such press increments
// the saturating drop_count. Without this option a full FIFO applies
// backpressure and no press is lost.
module user_button_event_collector #(
  parameter int NUM_BUTTONS = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_BUTTONS-1:0]               press_activated,
  output logic [NUM_BUTTONS-1:0]               press_accepted,
  output logic                                 event_valid,
  output logic [$clog2(NUM_BUTTONS)-1:0]       event_button,
  input  logic                                 event_pop,
  output logic [$clog2(FIFO_DEPTH):0]          event_count
`ifdef USER_BUTTON_EVENT_DROP_EN
  ,
  output logic [7:0]                           drop_count
`endif
);

  localparam int IDX_W = $clog2(NUM_BUTTONS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_LOW = 1'b1
  } chan_state_t;

  chan_state_t            state      [NUM_BUTTONS];
  chan_state_t            state_next [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] request;
  logic [NUM_BUTTONS-1:0] grant;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       rr_next;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_any;
  logic                   full;
  logic                   arb_enable;
  logic                   do_push;
  logic                   do_pop;
  logic [IDX_W-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;

  assign full = (count == CNT_W'(FIFO_DEPTH));

`ifdef USER_BUTTON_EVENT_DROP_EN
  // A full FIFO never stalls the arbiter. An overflowing press is acknowledged and then discarded.
  assign arb_enable = 1'b1;
`else
  // A full FIFO stalls the arbiter, so a pending press stays pending until space frees.
  assign arb_enable = ~full;
`endif

  assign do_push = grant_any & ~full;
  assign do_pop  = event_pop & (count != '0);

  // A button competes for the FIFO only while its channel is idle and its press is held.
  always_comb begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      request[i] = press_activated[i] && (state[i] == IDLE);
    end
  end

  // Round-robin search that starts at rr_ptr and stops at the first requester.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    grant     = '0;
    idx       = 0;
    for (int off = 0; off < NUM_BUTTONS; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NUM_BUTTONS) begin
        idx = idx - NUM_BUTTONS;
      end else begin
        idx = idx;
      end
      if (!grant_any && arb_enable && request[idx]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(idx);
      end else begin
        grant_any = grant_any;
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
      if (grant_idx == IDX_W'(NUM_BUTTONS - 1)) begin
        rr_next = '0;
      end else begin
        rr_next = grant_idx + IDX_W'(1);
      end
    end else begin
      rr_next = rr_ptr;
    end
  end

  // Channel next state: an accepted press waits for the button release before it can re-arm.
  always_comb begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      state_next[i] = state[i];
      case (state[i])
        IDLE: begin
          if (grant[i]) begin
            state_next[i] = WAIT_LOW;
          end else begin
            state_next[i] = IDLE;
          end
        end
        WAIT_LOW: begin
          if (!press_activated[i]) begin
            state_next[i] = IDLE;
          end else begin
            state_next[i] = WAIT_LOW;
          end
        end
        default: state_next[i] = IDLE;
      endcase
    end
  end

  // Register the channel states, the one-cycle acknowledge pulses and the round-robin pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        state[i] <= IDLE;
      end
      press_accepted <= '0;
      rr_ptr         <= '0;
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        state[i] <= state_next[i];
      end
      press_accepted <= grant;
      rr_ptr         <= rr_next;
    end
  end

  // Event FIFO. The occupancy count alone tells full from empty because the pointers simply wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= grant_idx;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef USER_BUTTON_EVENT_DROP_EN
  // Count the acknowledged presses that found the FIFO full. The count saturates at 255.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_count <= 8'd0;
    end else if (grant_any && full && (drop_count != 8'd255)) begin
      drop_count <= drop_count + 8'd1;
    end else begin
      drop_count <= drop_count;
    end
  end
`endif

  assign event_valid  = (count != '0);
  assign event_button = (count != '0) ? mem[rd_ptr] : '0;
  assign event_count  = count;

endmodule

// File: tb/tb_user_button_event_collector.sv
// Self-checking bench for user_button_event_collector with the default
// parameters NUM_BUTTONS=4 and FIFO_DEPTH=8. A table of single-cycle vectors
// covers the main handshake and FIFO behaviour. Hand-written sequences cover
// the full FIFO, a reset in the middle of a handshake and, when
// USER_BUTTON_EVENT_DROP_EN is defined, the drop counter.
module tb_user_button_event_collector;

  logic       clock;
  logic       reset;
  logic [3:0] press_activated;
  logic [3:0] press_accepted;
  logic       event_valid;
  logic [1:0] event_button;
  logic       event_pop;
  logic [3:0] event_count;
`ifdef USER_BUTTON_EVENT_DROP_EN
  logic [7:0] drop_count;
`endif

  int compared;
  int mismatched;

  user_button_event_collector #(.NUM_BUTTONS(4), .FIFO_DEPTH(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .press_activated (press_activated),
    .press_accepted  (press_accepted),
    .event_valid     (event_valid),
    .event_button    (event_button),
    .event_pop       (event_pop),
    .event_count     (event_count)
`ifdef USER_BUTTON_EVENT_DROP_EN
    ,
    .drop_count      (drop_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic [3:0] press;
    logic       pop;
    logic [3:0] acc;
    logic       valid;
    logic [1:0] btn;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] acc, input logic valid,
                         input logic [1:0] btn, input logic [3:0] cnt);
    chk({tag, ".press_accepted"}, 32'(press_accepted), 32'(acc));
    chk({tag, ".event_valid"},    32'(event_valid),    32'(valid));
    chk({tag, ".event_button"},   32'(event_button),   32'(btn));
    chk({tag, ".event_count"},    32'(event_count),    32'(cnt));
  endtask

  // Drive the inputs, let one clock edge pass, then settle 1 ns after it.
  task automatic step(input logic r, input logic [3:0] p, input logic pp);
    reset           = r;
    press_activated = p;
    event_pop       = pp;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
  endtask

  // Press button b and release it, leaving the FIFO otherwise untouched.
  task automatic press_once(input int b);
    logic [3:0] p;
    p = 4'b0001 << b;
    step(1'b0, p, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
  endtask

  initial begin
    int fill [8];
    int expq [$];
    compared        = 0;
    mismatched      = 0;
    reset           = 1'b1;
    press_activated = 4'b0000;
    event_pop       = 1'b0;

    // Fields: rst, press, pop | expected press_accepted, event_valid, event_button, event_count
    vecs[0]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 4'd1};
    vecs[1]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 4'd1};
    vecs[2]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 4'd1};
    vecs[3]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'd0};
    vecs[4]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 4'd0};
    vecs[5]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 4'd1};
    vecs[6]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 2'd0, 4'd2};
    vecs[7]  = '{1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 2'd0, 4'd3};
    vecs[8]  = '{1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1, 2'd0, 4'd4};
    vecs[9]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd1, 4'd3};
    vecs[10] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 4'd2};
    vecs[11] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 4'd1};
    vecs[12] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'd0};
    vecs[13] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 4'd1};
    vecs[14] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd1, 4'd2};
    vecs[15] = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd1, 4'd3};
    vecs[16] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd3, 4'd3};
    vecs[17] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 4'd2};
    vecs[18] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 4'd1};
    vecs[19] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'd0};
    vecs[20] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'd0};

    // Reset state
    do_reset();
    chk_all("reset", 4'b0000, 1'b0, 2'd0, 4'd0);
`ifdef USER_BUTTON_EVENT_DROP_EN
    chk("reset.drop_count", 32'(drop_count), 32'd0);
`endif

    // Table-driven vectors
    for (int i = 0; i < 21; i++) begin
      step(vecs[i].rst, vecs[i].press, vecs[i].pop);
      chk_all($sformatf("vec%0d", i), vecs[i].acc, vecs[i].valid, vecs[i].btn, vecs[i].cnt);
    end

    // Full FIFO applies backpressure. One pop frees a slot and the held press lands last.
    do_reset();
    fill = '{0, 2, 3, 0, 2, 3, 0, 2};
    for (int i = 0; i < 8; i++) press_once(fill[i]);
    chk("full.count", 32'(event_count), 32'd8);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b0010, 1'b0);
      chk("full.no_accept", 32'(press_accepted), 32'd0);
      chk("full.count_hold", 32'(event_count), 32'd8);
    end
    step(1'b0, 4'b0010, 1'b1);
    chk("full.pop_no_accept", 32'(press_accepted), 32'd0);
    chk("full.count_after_pop", 32'(event_count), 32'd7);
    step(1'b0, 4'b0010, 1'b0);
    chk("full.late_accept", 32'(press_accepted), 32'b0010);
    chk("full.count_refill", 32'(event_count), 32'd8);
    expq = '{2, 3, 0, 2, 3, 0, 2, 1};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("full.order%0d", i), 32'(event_button), 32'(expq[i]));
      step(1'b0, 4'b0000, 1'b1);
    end
    chk("full.drained", 32'(event_count), 32'd0);

    // Reset during WAIT_LOW while button 0 stays held
    do_reset();
    step(1'b0, 4'b0001, 1'b0);
    chk_all("rst_mid.accept", 4'b0001, 1'b1, 2'd0, 4'd1);
    step(1'b0, 4'b0001, 1'b0);
    chk("rst_mid.wait_low", 32'(press_accepted), 32'd0);
    #3;
    reset = 1'b1;
    #1;
    chk_all("rst_mid.async", 4'b0000, 1'b0, 2'd0, 4'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk_all("rst_mid.reaccept", 4'b0001, 1'b1, 2'd0, 4'd1);
    step(1'b0, 4'b0001, 1'b0);
    chk_all("rst_mid.once", 4'b0000, 1'b1, 2'd0, 4'd1);

`ifdef USER_BUTTON_EVENT_DROP_EN
    // Presses into a full FIFO are acknowledged and dropped. drop_count saturates at 255.
    do_reset();
    for (int i = 0; i < 8; i++) press_once(fill[i]);
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 4'b0010, 1'b0);
      chk("drop.ack", 32'(press_accepted), 32'b0010);
      chk("drop.count", 32'(event_count), 32'd8);
      step(1'b0, 4'b0000, 1'b0);
    end
    chk("drop.saturated", 32'(drop_count), 32'd255);
    chk("drop.head", 32'(event_button), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
